// File: rtl/pacemaker_pm.sv
// Dual-chamber (DDD-style) pacemaker timing controller: escape/AV/refractory timing with pa/pv pace pulses.
// Define PM_SYNC_INPUTS_EN to add a 2-flop synchronizer on sa/sv ahead of edge detection.
module pacemaker_pm #(
  parameter int AEI     = 100,
  parameter int AVI     = 30,
  parameter int REF     = 20,
  parameter int PULSE_W = 2,
  parameter int CW      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sa,
  input  logic sv,
  output logic pa,
  output logic pv
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_V  = 2'd1,
    REFRACT = 2'd2
  } state_t;

  localparam logic [CW-1:0] AEI_M1 = CW'(AEI - 1);
  localparam logic [CW-1:0] AVI_M1 = CW'(AVI - 1);
  localparam logic [CW-1:0] REF_M1 = CW'(REF - 1);
  localparam logic [CW-1:0] PW_M1  = CW'(PULSE_W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] pa_cnt_q, pa_cnt_d;
  logic [CW-1:0] pv_cnt_q, pv_cnt_d;
  logic          pa_q, pa_d;
  logic          pv_q, pv_d;
  logic          sa_q, sv_q;
  logic          sa_in, sv_in;
  logic          sa_ev, sv_ev;
  logic          pa_start, pv_start;

`ifdef PM_SYNC_INPUTS_EN
  logic [1:0] sa_sync_q, sv_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_sync_q <= 2'b00;
      sv_sync_q <= 2'b00;
    end else begin
      sa_sync_q <= {sa_sync_q[0], sa};
      sv_sync_q <= {sv_sync_q[0], sv};
    end
  end

  assign sa_in = sa_sync_q[1];
  assign sv_in = sv_sync_q[1];
`else
  assign sa_in = sa;
  assign sv_in = sv;
`endif

  // A level held high produces exactly one event, on its first sampled-high edge.
  assign sa_ev = sa_in & ~sa_q;
  assign sv_ev = sv_in & ~sv_q;

  always_comb begin
    state_d  = state_q;
    pa_start = 1'b0;
    pv_start = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (sv_ev) begin
          state_d = REFRACT;
        end else if (sa_ev) begin
          state_d = WAIT_V;
        end else if (timer_q == AEI_M1) begin
          state_d  = WAIT_V;
          pa_start = 1'b1;
        end
      end
      WAIT_V: begin
        if (sv_ev) begin
          state_d = REFRACT;
        end else if (timer_q == AVI_M1) begin
          state_d  = REFRACT;
          pv_start = 1'b1;
        end
      end
      REFRACT: begin
        if (timer_q == REF_M1) begin
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase

    timer_d = (state_d != state_q) ? '0 : timer_q + CW'(1);

    // Pulses run on their own counters so a state change never truncates them.
    pa_d     = pa_start | (pa_cnt_q != '0);
    pa_cnt_d = pa_start ? PW_M1 : ((pa_cnt_q != '0) ? pa_cnt_q - CW'(1) : '0);
    pv_d     = pv_start | (pv_cnt_q != '0);
    pv_cnt_d = pv_start ? PW_M1 : ((pv_cnt_q != '0) ? pv_cnt_q - CW'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_A;
      timer_q  <= '0;
      pa_cnt_q <= '0;
      pv_cnt_q <= '0;
      pa_q     <= 1'b0;
      pv_q     <= 1'b0;
      sa_q     <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pa_cnt_q <= pa_cnt_d;
      pv_cnt_q <= pv_cnt_d;
      pa_q     <= pa_d;
      pv_q     <= pv_d;
      sa_q     <= sa_in;
      sv_q     <= sv_in;
    end
  end

  assign pa = pa_q;
  assign pv = pv_q;

endmodule

// File: tb/tb_pacemaker_pm.sv
// Testbench for pacemaker_pm: directed scenarios plus random sensing, checked every cycle
// against a deadline-based reference model.
module tb_pacemaker_pm;

  localparam int AEI     = 100;
  localparam int AVI     = 30;
  localparam int REF     = 20;
  localparam int PULSE_W = 2;
  localparam int CW      = 16;
`ifdef PM_SYNC_INPUTS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int M_A = 0;
  localparam int M_V = 1;
  localparam int M_R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sa  = 1'b0;
  logic sv  = 1'b0;
  logic pa, pv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pacemaker_pm #(
    .AEI(AEI), .AVI(AVI), .REF(REF), .PULSE_W(PULSE_W), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sa (sa),
    .sv (sv),
    .pa (pa),
    .pv (pv)
  );

  // Reference model: absolute edge count, current mode and the edge at which it times out.
  int n = 0;
  int mode = M_A;
  int deadline = 0;
  int pa_begin = -1000;
  int pv_begin = -1000;
  bit sa_p = 0, sv_p = 0;
  bit sa_h1 = 0, sa_h2 = 0, sv_h1 = 0, sv_h2 = 0;

  int   pa_rises[$];
  int   pv_rises[$];
  logic pa_prev = 1'b0, pv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit v);
    bit a_in, v_in, a_ev, v_ev, exp_pa, exp_pv;
    rst = r;
    sa  = a;
    sv  = v;
    @(posedge clk);
    n++;
`ifdef PM_SYNC_INPUTS_EN
    a_in  = sa_h2;
    v_in  = sv_h2;
    sa_h2 = r ? 1'b0 : sa_h1;
    sa_h1 = r ? 1'b0 : a;
    sv_h2 = r ? 1'b0 : sv_h1;
    sv_h1 = r ? 1'b0 : v;
`else
    a_in = a;
    v_in = v;
`endif
    a_ev = a_in && !sa_p;
    v_ev = v_in && !sv_p;
    if (r) begin
      mode     = M_A;
      deadline = n + AEI;
      pa_begin = -1000;
      pv_begin = -1000;
      sa_p     = 0;
      sv_p     = 0;
    end else begin
      if (mode == M_A) begin
        if (v_ev) begin
          mode = M_R; deadline = n + REF;
        end else if (a_ev) begin
          mode = M_V; deadline = n + AVI;
        end else if (n == deadline) begin
          pa_begin = n; mode = M_V; deadline = n + AVI;
        end
      end else if (mode == M_V) begin
        if (v_ev) begin
          mode = M_R; deadline = n + REF;
        end else if (n == deadline) begin
          pv_begin = n; mode = M_R; deadline = n + REF;
        end
      end else begin
        if (n == deadline) begin
          mode = M_A; deadline = n + AEI;
        end
      end
      sa_p = a_in;
      sv_p = v_in;
    end
    exp_pa = (n >= pa_begin) && (n < pa_begin + PULSE_W);
    exp_pv = (n >= pv_begin) && (n < pv_begin + PULSE_W);
    @(negedge clk);
    check("pa", {31'd0, pa}, {31'd0, exp_pa});
    check("pv", {31'd0, pv}, {31'd0, exp_pv});
    if (pa === 1'b1 && pa_prev !== 1'b1) pa_rises.push_back(n);
    if (pv === 1'b1 && pv_prev !== 1'b1) pv_rises.push_back(n);
    pa_prev = pa;
    pv_prev = pv;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    pa_rises.delete();
    pv_rises.delete();
  endtask

  initial begin
    int rst_edge, rst_edge2, sa_edge, sv_edge;
    bit sa_lvl, sv_lvl;

    @(negedge clk);

    // Test 1: free pacing after reset.
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);
    check("reset_pa", {31'd0, pa}, 32'd0);
    check("reset_pv", {31'd0, pv}, 32'd0);
    rst_edge = n;
    clear_log();
    idle(320);
    check("t1_pa_count", pa_rises.size(), 2);
    check("t1_pv_count", pv_rises.size(), 2);
    if (pa_rises.size() >= 2 && pv_rises.size() >= 1) begin
      check("t1_first_pa", pa_rises[0] - rst_edge, AEI);
      check("t1_pa_to_pv", pv_rises[0] - pa_rises[0], AVI);
      check("t1_pv_to_pa", pa_rises[1] - pv_rises[0], REF + AEI);
      $display("test1 pa at +%0d, pv at +%0d, next pa at +%0d", pa_rises[0] - rst_edge,
               pv_rises[0] - rst_edge, pa_rises[1] - rst_edge);
    end

    // Test 2: natural atrial beat suppresses pa, pv follows after AVI.
    step(1'b1, 1'b0, 1'b0);
    clear_log();
    idle(10);
    step(1'b0, 1'b1, 1'b0);
    sa_edge = n;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    idle(60);
    check("t2_pa_count", pa_rises.size(), 0);
    check("t2_pv_count", pv_rises.size(), 1);
    if (pv_rises.size() >= 1) begin
      check("t2_sa_to_pv", pv_rises[0] - sa_edge, AVI + LAT);
      $display("test2 pv at +%0d after sa edge", pv_rises[0] - sa_edge);
    end

    // Test 3: sa then sv 20 cycles later -> no pv; next pa REF+AEI after sv.
    step(1'b1, 1'b0, 1'b0);
    clear_log();
    idle(10);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    sv_edge = n;
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1);
    idle(110);
    check("t3_pv_count", pv_rises.size(), 0);
    check("t3_pa_count", pa_rises.size(), 1);
    if (pa_rises.size() >= 1) begin
      check("t3_sv_to_pa", pa_rises[0] - sv_edge, REF + AEI + LAT);
      $display("test3 pa at +%0d after sv edge", pa_rises[0] - sv_edge);
    end

    // Test 4: held sv is one event; sa inside refractory is ignored.
    step(1'b1, 1'b0, 1'b0);
    clear_log();
    idle(10);
    step(1'b0, 1'b0, 1'b1);
    sv_edge = n;
    for (int i = 1; i < 25; i++) step(1'b0, (i >= 10 && i < 15), 1'b1);
    idle(110);
    check("t4_pv_count", pv_rises.size(), 0);
    check("t4_pa_count", pa_rises.size(), 1);
    if (pa_rises.size() >= 1) begin
      check("t4_sv_to_pa", pa_rises[0] - sv_edge, REF + AEI + LAT);
      $display("test4 pa at +%0d after sv edge", pa_rises[0] - sv_edge);
    end

    // Test 5: reset while pa is high.
    step(1'b1, 1'b0, 1'b0);
    rst_edge = n;
    idle(AEI);
    check("t5_pa_high", {31'd0, pa}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    rst_edge2 = n;
    check("t5_pa_cleared", {31'd0, pa}, 32'd0);
    clear_log();
    idle(AEI + 5);
    check("t5_pa_count", pa_rises.size(), 1);
    if (pa_rises.size() >= 1) begin
      check("t5_restart", pa_rises[0] - rst_edge2, AEI);
      $display("test5 pa at +%0d after reset (first run pa at +%0d)", pa_rises[0] - rst_edge2,
               AEI + rst_edge - rst_edge);
    end

    // Random sensing with occasional resets, checked cycle by cycle.
    sa_lvl = 0;
    sv_lvl = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 29) == 0) sa_lvl = !sa_lvl;
      if ($urandom_range(0, 39) == 0) sv_lvl = !sv_lvl;
      if ($urandom_range(0, 699) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b1, sa_lvl, sv_lvl);
      end else begin
        step(1'b0, sa_lvl, sv_lvl);
      end
    end
    $display("random phase done at cycle %0d", n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
